// File: rtl/creg_file_a_pkg.sv
// Shared helpers for the ephemeral-register family.
// Address sizing used by creg_file_a and its chain stages.
package creg_file_a_pkg;

  function automatic int addr_bits(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/creg_file_a_chain_stage.sv
// One ordering step of the per-entry port chain:
// replaces the running value when this port writes the entry.
module creg_chain_stage #(
  parameter int width  = 8,
  parameter int addr_w = 2,
  parameter int entry  = 0
) (
  input  logic [width-1:0]  val_i,
  input  logic              en_i,
  input  logic [addr_w-1:0] addr_i,
  input  logic [width-1:0]  data_i,
  output logic [width-1:0]  val_o
);

  localparam logic [addr_w-1:0] Idx = addr_w'(entry);

  logic hit;

  assign hit   = en_i && (addr_i == Idx);
  assign val_o = hit ? data_i : val_i;

endmodule

// File: rtl/creg_file_a.sv
// Ordered multi-port register file: CLR, then ports 0..ports-1
// apply in sequence within a cycle; reads see lower-port writes.
module creg_file_a
  import creg_file_a_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 4,
  parameter int ports = 5,
  parameter logic [width-1:0] init = '0,
  localparam int addr_w = addr_bits(depth)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLR,
  input  logic [ports-1:0]          EN,
  input  logic [ports*addr_w-1:0]   ADDR,
  input  logic [ports*width-1:0]    D_IN,
  output logic [ports*width-1:0]    Q_OUT
);

  logic [width-1:0] e_q [depth];
  logic [width-1:0] e_d [depth];
  logic [width-1:0] rd  [ports][depth];
  logic [ports*width-1:0] q_d;

  for (genvar e = 0; e < depth; e++) begin : g_ent
    logic [width-1:0] base;

    assign base = CLR ? init : e_q[e];

    for (genvar k = 0; k < ports; k++) begin : g_port
      logic [width-1:0] vi;
      logic [width-1:0] vo;

      if (k == 0) begin : g_first
        assign vi = base;
      end else begin : g_next
        assign vi = g_port[k-1].vo;
      end

      // value of entry e as seen by port k
      assign rd[k][e] = vi;

      creg_chain_stage #(
        .width  (width),
        .addr_w (addr_w),
        .entry  (e)
      ) u_stage (
        .val_i  (vi),
        .en_i   (EN[k]),
        .addr_i (ADDR[slice_lo(k, addr_w) +: addr_w]),
        .data_i (D_IN[slice_lo(k, width) +: width]),
        .val_o  (vo)
      );
    end

    assign e_d[e] = g_port[ports-1].vo;
  end

  // out-of-range addresses never hold data, so they read as init
  always_comb begin
    q_d = '0;
    for (int k = 0; k < ports; k++) begin
      if (int'(ADDR[k*addr_w +: addr_w]) < depth) begin
        q_d[k*width +: width] = rd[k][ADDR[k*addr_w +: addr_w]];
      end else begin
        q_d[k*width +: width] = init;
      end
    end
  end

  assign Q_OUT = q_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int e = 0; e < depth; e++) begin
        e_q[e] <= init;
      end
    end else begin
      for (int e = 0; e < depth; e++) begin
        e_q[e] <= e_d[e];
      end
    end
  end

endmodule
